// File: rtl/hash_des_arbiter.sv
// Two-requester round-robin front end for a single full_hash_des_box core:
// grants the core, forwards one message, collects the digest, pulses done/err.
module hash_des_arbiter #(
  parameter int HASH_LAT = 3,
  parameter int TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [63:0] len0,
  input  logic [63:0] len1,
  input  logic [7:0]  byte0,
  input  logic [7:0]  byte1,
  input  logic        bval0,
  input  logic        bval1,
  output logic [1:0]  gnt,
  output logic [31:0] digest,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic        h_M_valid,
  output logic [7:0]  h_message,
  output logic [63:0] h_counter,
  input  logic [31:0] h_digest_out,
  input  logic        h_hash_ready
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ZERO, STREAM, WAIT, DONE} state_t;

  state_t        state;
  logic          ptr;
  logic          g_q;
  logic [63:0]   len_q;
  logic [63:0]   cnt;
  logic [WW-1:0] wcnt;

  logic          pick;
  logic [63:0]   len_pick;
  logic          bval_g;
  logic [7:0]    byte_g;

  // Contention goes to ptr; a lone request always wins.
  always_comb begin
    pick     = (req == 2'b11) ? ptr : req[1];
    len_pick = pick ? len1 : len0;
    bval_g   = g_q ? bval1 : bval0;
    byte_g   = g_q ? byte1 : byte0;
  end

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // blocking assignments would make the result depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      g_q       <= 1'b0;
      len_q     <= '0;
      cnt       <= '0;
      wcnt      <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      digest    <= '0;
      h_M_valid <= 1'b0;
      h_message <= '0;
      h_counter <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        IDLE: begin
          h_M_valid <= 1'b0;
          if (req != 2'b00) begin
            g_q       <= pick;
            len_q     <= len_pick;
            cnt       <= '0;
            wcnt      <= '0;
            gnt       <= pick ? 2'b10 : 2'b01;
            h_counter <= len_pick;
            h_message <= '0;
            // An empty message still needs one M_valid beat with counter 0.
            if (len_pick == 64'd0) begin
              h_M_valid <= 1'b1;
              state     <= ZERO;
            end else begin
              state <= STREAM;
            end
          end
        end

        ZERO: begin
          h_M_valid <= 1'b0;
          gnt       <= '0;
          state     <= WAIT;
        end

        STREAM: begin
          h_M_valid <= bval_g;
          h_message <= byte_g;
          if (bval_g) begin
            cnt <= cnt + 64'd1;
            if (cnt == len_q - 64'd1) begin
              gnt   <= '0;
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          h_M_valid <= 1'b0;
          if (wcnt >= WW'(HASH_LAT) && h_hash_ready) begin
            digest <= h_digest_out;
            done   <= g_q ? 2'b10 : 2'b01;
            state  <= DONE;
          end else if (wcnt == WW'(TIMEOUT - 1)) begin
            err   <= g_q ? 2'b10 : 2'b01;
            ptr   <= ~ptr;
            state <= IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end

        DONE: begin
          ptr   <= ~g_q;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_des_arbiter.sv
// Randomised bench for hash_des_arbiter with a behavioural hash core, a
// grant/ptr monitor and per-requester drivers checking digest and latency.
module tb_hash_des_arbiter;
  localparam int HASH_LAT = 3;
  localparam int TIMEOUT  = 64;
  localparam int MAXLEN   = 96;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [63:0] len0, len1;
  logic [7:0]  byte0, byte1;
  logic        bval0, bval1;
  logic [1:0]  gnt, done, err;
  logic [31:0] digest;
  logic        h_M_valid;
  logic [7:0]  h_message;
  logic [63:0] h_counter;
  logic [31:0] h_digest_out;
  logic        h_hash_ready;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] msgs [2][MAXLEN];
  string      vec81;
  logic       ready_en;

  hash_des_arbiter #(.HASH_LAT(HASH_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req),
    .len0(len0), .len1(len1), .byte0(byte0), .byte1(byte1),
    .bval0(bval0), .bval1(bval1),
    .gnt(gnt), .digest(digest), .done(done), .err(err),
    .h_M_valid(h_M_valid), .h_message(h_message), .h_counter(h_counter),
    .h_digest_out(h_digest_out), .h_hash_ready(h_hash_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Known vectors of the real core, otherwise an order-sensitive FNV-style mix.
  function automatic logic [31:0] ref_digest(input logic [7:0] m[$]);
    logic [31:0] h;
    bit same;
    if (m.size() == 0) return 32'h83656fd2;
    if (m.size() == 2 && m[0] == 8'h41 && m[1] == 8'h42) return 32'h83656fd4;
    if (m.size() == 81) begin
      same = 1'b1;
      for (int i = 0; i < 81; i++) if (m[i] != vec81[i]) same = 1'b0;
      if (same) return 32'hc0872334;
    end
    h = 32'h811c9dc5;
    foreach (m[i]) h = (h ^ {24'd0, m[i]}) * 32'h01000193;
    return h ^ 32'(m.size());
  endfunction

  // Behavioural core: gathers one message per h_counter, then raises ready.
  logic [7:0]  core_q[$];
  logic        core_busy;
  logic [63:0] core_ctr, last_ctr;
  int          core_beats, core_first, core_t, last_beats, last_span;
  initial begin
    h_hash_ready = 1'b0;
    h_digest_out = '0;
    core_busy    = 1'b0;
    core_t       = 0;
    forever begin
      @(posedge clk);
      core_t++;
      if (rst) begin
        core_busy = 1'b0;
        h_hash_ready <= 1'b0;
        h_digest_out <= '0;
      end else if (h_M_valid) begin
        if (!core_busy) begin
          core_busy  = 1'b1;
          core_q.delete();
          core_ctr   = h_counter;
          core_beats = 0;
          core_first = core_t;
          h_hash_ready <= 1'b0;
        end
        core_beats++;
        if (core_ctr != 0) core_q.push_back(h_message);
        if (core_ctr == 0 || 64'(core_q.size()) == core_ctr) begin
          core_busy  = 1'b0;
          last_ctr   = core_ctr;
          last_beats = core_beats;
          last_span  = core_t - core_first + 1;
          h_digest_out <= ref_digest(core_q);
          h_hash_ready <= ready_en;
        end
      end
    end
  end

  // Grant monitor: one-hot grant, round-robin pick, h_counter at grant.
  logic       ptr_m, exp_g, rst_s;
  logic [1:0] req_s, gnt_prev;
  initial begin
    ptr_m = 1'b0;
    gnt_prev = '0;
    forever begin
      @(posedge clk);
      req_s = req;
      rst_s = rst;
      @(negedge clk);
      if (rst_s) begin
        ptr_m = 1'b0;
        gnt_prev = '0;
      end else begin
        check("gnt_onehot", 64'($countones(gnt) <= 1), 64'd1);
        if (gnt_prev == 2'b00 && gnt != 2'b00) begin
          exp_g = (req_s == 2'b11) ? ptr_m : req_s[1];
          check("gnt_pick", 64'(gnt), exp_g ? 64'd2 : 64'd1);
          check("h_counter_at_grant", h_counter, exp_g ? len1 : len0);
        end
        if (done != 2'b00) ptr_m = ~done[1];
        if (err != 2'b00) ptr_m = ~ptr_m;
        gnt_prev = gnt;
      end
    end
  end

  task automatic drive(input int id, input logic [7:0] b, input logic v);
    if (id == 0) begin byte0 = b; bval0 = v; end
    else         begin byte1 = b; bval1 = v; end
  endtask

  task automatic fill_random(input int id, input int len);
    for (int i = 0; i < len; i++) msgs[id][i] = 8'($urandom);
  endtask

  // gap_mode: 0 random gaps, 1 continuous, 2 one gap after the first byte.
  task automatic requester(input int id, input int len, input int gap_mode, input bit exp_err);
    logic [7:0]  q[$];
    logic [31:0] dig_before;
    logic        b;
    int          idx, t_end, n, s;
    idx = 0; t_end = 0; n = 0; s = 0;
    for (int i = 0; i < len; i++) q.push_back(msgs[id][i]);
    if (id == 0) len0 = 64'(len); else len1 = 64'(len);
    req[id] = 1'b1;
    while (!gnt[id] && n < 500) begin
      drive(id, 8'($urandom), 1'($urandom_range(0, 1)));
      @(negedge clk);
      n++;
    end
    check($sformatf("grant_wait%0d", id), 64'(gnt[id]), 64'd1);
    if (!gnt[id]) begin req[id] = 1'b0; return; end
    dig_before = digest;
    if (len == 0) t_end = cyc + 1;
    n = 0;
    while (idx < len && n < 2000) begin
      case (gap_mode)
        1:       b = 1'b1;
        2:       b = (s != 1);
        default: b = ($urandom_range(0, 3) != 0);
      endcase
      drive(id, q[idx], b);
      if (b) begin
        idx++;
        if (idx == len) t_end = cyc + 1;
      end
      s++; n++;
      @(negedge clk);
    end
    if (len > 0) check($sformatf("gnt_drop%0d", id), 64'(gnt[id]), 64'd0);
    n = 0;
    while (done[id] == 1'b0 && err[id] == 1'b0 && n < TIMEOUT + 40) begin
      drive(id, 8'($urandom), n < 3);
      @(negedge clk);
      n++;
    end
    check($sformatf("done%0d", id), 64'(done[id]), 64'(!exp_err));
    check($sformatf("err%0d", id), 64'(err[id]), 64'(exp_err));
    check($sformatf("latency%0d", id), 64'(cyc),
          exp_err ? 64'(t_end + TIMEOUT) : 64'(t_end + HASH_LAT + 1));
    if (!exp_err) begin
      check($sformatf("digest%0d", id), 64'(digest), 64'(ref_digest(q)));
      check($sformatf("core_counter%0d", id), last_ctr, 64'(len));
      check($sformatf("core_beats%0d", id), 64'(last_beats), (len == 0) ? 64'd1 : 64'(len));
      if (gap_mode == 1) check("span_continuous", 64'(last_span), (len == 0) ? 64'd1 : 64'(len));
      if (gap_mode == 2) check("span_gap", 64'(last_span), 64'(len + 1));
    end else begin
      check($sformatf("digest_held%0d", id), 64'(digest), 64'(dig_before));
    end
    req[id] = 1'b0;
    drive(id, 8'd0, 1'b0);
    @(negedge clk);
    check($sformatf("pulse_end%0d", id), 64'(done[id] | err[id]), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, la, lb, ga, gb;
    vec81 = "HARDWARE_AND_EMBEDDED_SECURITY_FULL_HASH_DES_BOX_PROJECT_bigliazzi_venturini_2022";
    ready_en = 1'b1;
    req = '0; len0 = '0; len1 = '0; byte0 = '0; byte1 = '0; bval0 = 1'b0; bval1 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("reset_outputs", {gnt, done, err, 31'd0, h_M_valid}, 64'd0);
    check("reset_bus", {digest, 24'd0, h_message}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Zero-length message on requester 0.
    requester(0, 0, 1, 1'b0);
    check("zero_digest", 64'(digest), 64'h83656fd2);

    // Reset in the middle of a stream.
    fill_random(0, 20);
    len0 = 64'd20;
    req  = 2'b01;
    for (int i = 0; i < 20 && !gnt[0]; i++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin drive(0, msgs[0][i] | 8'h80, 1'b1); @(negedge clk); end
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ctrl", {gnt, done, err, 31'd0, h_M_valid}, 64'd0);
    check("rst_mid_bus", {digest, 24'd0, h_message}, 64'd0);
    check("rst_mid_counter", h_counter, 64'd0);
    @(negedge clk);
    rst = 1'b0; req = 2'b00; drive(0, 8'd0, 1'b0);
    @(negedge clk);
    fill_random(0, 5);
    requester(0, 5, 1, 1'b0);

    // Leave ptr at 0, then both requesters send "AB".
    fill_random(1, 3);
    requester(1, 3, 0, 1'b0);
    msgs[0][0] = 8'h41; msgs[0][1] = 8'h42;
    msgs[1][0] = 8'h41; msgs[1][1] = 8'h42;
    fork
      requester(0, 2, 1, 1'b0);
      requester(1, 2, 1, 1'b0);
    join
    check("ab_digest", 64'(digest), 64'h83656fd4);

    // Requester 1 sends "A", a gap, then "B".
    requester(1, 2, 2, 1'b0);

    // 81-byte known vector, continuous.
    for (int i = 0; i < 81; i++) msgs[0][i] = vec81[i];
    requester(0, 81, 1, 1'b0);
    check("vec81_digest", 64'(digest), 64'hc0872334);

    // Timeout on requester 1 (ptr was 1), then contention must go to 0.
    ready_en = 1'b0;
    fill_random(1, 4);
    requester(1, 4, 0, 1'b1);
    ready_en = 1'b1;
    fill_random(0, 3); fill_random(1, 3);
    fork
      requester(0, 3, 0, 1'b0);
      requester(1, 3, 0, 1'b0);
    join

    // Randomised mix of single and contended transactions.
    for (int it = 0; it < 30; it++) begin
      mode = $urandom_range(0, 2);
      la = $urandom_range(0, 12); lb = $urandom_range(0, 12);
      ga = $urandom_range(0, 1);  gb = $urandom_range(0, 1);
      fill_random(0, la); fill_random(1, lb);
      case (mode)
        0: requester(0, la, ga, 1'b0);
        1: requester(1, lb, gb, 1'b0);
        default: fork
          requester(0, la, ga, 1'b0);
          requester(1, lb, gb, 1'b0);
        join
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
